// File: rtl/spike_pkg.sv
// Shared types and default sizes for the spike collector.
// The event struct here matches the default parameter set; the top builds
// its own struct from its actual parameters and hands it to the FIFO.
package spike_pkg;

   localparam int SPK_NUM_NEURONS     = 4;
   localparam int SPK_TIMESTAMP_WIDTH = 16;
   localparam int SPK_FIFO_DEPTH      = 16;
   localparam int SPK_DROP_WIDTH      = 8;
   localparam int SPK_NEURON_WIDTH    = $clog2(SPK_NUM_NEURONS);

   // One collected spike: source neuron, onset/refractory-end flag, sample time.
   typedef struct packed {
      logic [SPK_NEURON_WIDTH-1:0]    neuron;
      logic                           on_off;
      logic [SPK_TIMESTAMP_WIDTH-1:0] timestamp;
   } spike_event_t;

endpackage

// File: rtl/spike_out_if.sv
// Per-neuron spike output port. No backpressure: the producer pulses valid
// for one cycle per event and never waits for the receiver.
interface spike_out_if;

   logic valid;
   logic on_off;

   modport master (output valid, output on_off);
   modport slave  (input  valid, input  on_off);

endinterface

// File: rtl/spike_event_fifo.sv
// First-word-fall-through event FIFO. The head is visible combinationally
// whenever the FIFO is non-empty and reads as zero when it is empty.
// A push while full and a pop while empty are ignored. flush empties the
// FIFO and wins over push/pop in the same cycle.
module spike_event_fifo
   import spike_pkg::*;
#(
   parameter int  DEPTH = SPK_FIFO_DEPTH,
   parameter type T     = spike_event_t
) (
   input  logic clk,
   input  logic reset,
   input  logic flush,
   input  logic push,
   input  T     push_data,
   input  logic pop,
   output T     head,
   output logic empty,
   output logic full
);

   localparam int AW = $clog2(DEPTH);

   T             mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic         do_push;
   logic         do_pop;

   // Extra pointer MSB separates the full and empty cases when the low bits match.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                    (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Next pointer values; flush overrides any push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // Pointer registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents only matter between the pointers, so no reset.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

   // Head read-out, forced to zero when there is nothing to show.
   always_comb begin
      head = '0;
      if (!empty) head = mem_q[rd_ptr_q[AW-1:0]];
   end

endmodule

// File: rtl/spike_collector.sv
// Receiving end of the neuron spike interfaces.
// Every cycle each input that fires is captured into its own pending slot
// together with the free-running timestamp. A round-robin arbiter moves one
// pending slot per cycle into the event FIFO, whose head is offered on a
// valid/ready stream.
// Output stream handshake: an event transfers on a rising clk edge where
// event_valid && event_ready; while event_valid is high and event_ready is
// low, the head fields hold steady.
// A spike arriving on an input whose slot is still pending (and not being
// granted in that cycle) is lost: drop_count counts it (saturating) and
// overflow latches.
module spike_collector
   import spike_pkg::*;
#(
   parameter int NUM_NEURONS     = SPK_NUM_NEURONS,
   parameter int TIMESTAMP_WIDTH = SPK_TIMESTAMP_WIDTH,
   parameter int FIFO_DEPTH      = SPK_FIFO_DEPTH,
   parameter int DROP_WIDTH      = SPK_DROP_WIDTH
) (
   input  logic                           clk,
   input  logic                           reset,
   spike_out_if.slave                     spike_in [NUM_NEURONS],
   input  logic                           clear,
   output logic                           event_valid,
   input  logic                           event_ready,
   output logic [$clog2(NUM_NEURONS)-1:0] event_neuron,
   output logic                           event_on_off,
   output logic [TIMESTAMP_WIDTH-1:0]     event_timestamp,
   output logic [DROP_WIDTH-1:0]          drop_count,
   output logic                           overflow
);

   localparam int NW = $clog2(NUM_NEURONS);

   typedef struct packed {
      logic [NW-1:0]              neuron;
      logic                       on_off;
      logic [TIMESTAMP_WIDTH-1:0] timestamp;
   } event_t;

   // Flattened copies of the spike interfaces.
   logic [NUM_NEURONS-1:0]     spk_valid;
   logic [NUM_NEURONS-1:0]     spk_on;

   logic [TIMESTAMP_WIDTH-1:0] ts_q, ts_d;
   logic [NUM_NEURONS-1:0]     pending_q, pending_d;
   logic [NUM_NEURONS-1:0]     slot_on_q, slot_on_d;
   logic [TIMESTAMP_WIDTH-1:0] slot_ts_q [NUM_NEURONS];
   logic [TIMESTAMP_WIDTH-1:0] slot_ts_d [NUM_NEURONS];
   logic [NW-1:0]              rr_q, rr_d;
   logic [DROP_WIDTH-1:0]      drop_q, drop_d;
   logic                       ovf_q, ovf_d;

   logic                       grant_valid;
   logic [NW-1:0]              grant_idx;
   event_t                     push_ev;
   event_t                     head_ev;
   logic                       fifo_empty;
   logic                       fifo_full;

   for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_in
      assign spk_valid[g] = spike_in[g].valid;
      assign spk_on[g]    = spike_in[g].on_off;
   end

   // Round-robin pick: first pending slot at or after rr_q, only when the FIFO has room.
   always_comb begin
      int unsigned idx;
      logic [NW-1:0] sel;
      idx         = 0;
      sel         = '0;
      grant_valid = 1'b0;
      grant_idx   = '0;
      if (!fifo_full) begin
         for (int unsigned k = 0; k < NUM_NEURONS; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= NUM_NEURONS) idx = idx - NUM_NEURONS;
            sel = NW'(idx);
            if (!grant_valid && pending_q[sel]) begin
               grant_valid = 1'b1;
               grant_idx   = sel;
            end
         end
      end
   end

   // Event written into the FIFO: the granted slot's stored contents.
   always_comb begin
      push_ev           = '0;
      push_ev.neuron    = grant_idx;
      push_ev.on_off    = slot_on_q[grant_idx];
      push_ev.timestamp = slot_ts_q[grant_idx];
   end

   // Slot capture, collision accounting, pointer advance and timestamp count.
   always_comb begin
      ts_d      = ts_q + 1'b1;
      pending_d = pending_q;
      slot_on_d = slot_on_q;
      slot_ts_d = slot_ts_q;
      rr_d      = rr_q;
      drop_d    = drop_q;
      ovf_d     = ovf_q;
      if (clear) begin
         // Clear discards this cycle's spikes and grant; the RR pointer is kept.
         ts_d      = '0;
         pending_d = '0;
         drop_d    = '0;
         ovf_d     = 1'b0;
      end else begin
         // Freeing the granted slot first lets a same-cycle spike reload it.
         if (grant_valid) begin
            pending_d[grant_idx] = 1'b0;
            rr_d = (grant_idx == NW'(NUM_NEURONS - 1)) ? '0 : grant_idx + 1'b1;
         end
         for (int i = 0; i < NUM_NEURONS; i++) begin
            if (spk_valid[i]) begin
               if (pending_d[i]) begin
                  ovf_d = 1'b1;
                  if (drop_d != {DROP_WIDTH{1'b1}}) drop_d = drop_d + 1'b1;
               end else begin
                  pending_d[i] = 1'b1;
                  slot_on_d[i] = spk_on[i];
                  slot_ts_d[i] = ts_q;
               end
            end
         end
      end
   end

   // State registers for counter, slots, arbiter pointer and drop tracking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ts_q      <= '0;
         pending_q <= '0;
         slot_on_q <= '0;
         for (int i = 0; i < NUM_NEURONS; i++) slot_ts_q[i] <= '0;
         rr_q      <= '0;
         drop_q    <= '0;
         ovf_q     <= 1'b0;
      end else begin
         ts_q      <= ts_d;
         pending_q <= pending_d;
         slot_on_q <= slot_on_d;
         slot_ts_q <= slot_ts_d;
         rr_q      <= rr_d;
         drop_q    <= drop_d;
         ovf_q     <= ovf_d;
      end
   end

   spike_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (event_t)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (clear),
      .push      (grant_valid),
      .push_data (push_ev),
      .pop       (event_ready),
      .head      (head_ev),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign event_valid     = !fifo_empty;
   assign event_neuron    = head_ev.neuron;
   assign event_on_off    = head_ev.on_off;
   assign event_timestamp = head_ev.timestamp;
   assign drop_count      = drop_q;
   assign overflow        = ovf_q;

endmodule

// File: tb/tb_spike_collector.sv
// Bench for spike_collector with default parameters (4 inputs, 16-bit
// timestamps, 16-entry FIFO, 8-bit drop counter).
module tb_spike_collector;

   localparam int N     = 4;
   localparam int DEPTH = 16;

   logic        clk;
   logic        reset;
   logic        clr;
   logic        rdy;
   logic [3:0]  v_m;
   logic [3:0]  o_m;
   logic        ev_valid;
   logic [1:0]  ev_neuron;
   logic        ev_on;
   logic [15:0] ev_ts;
   logic [7:0]  drop_cnt;
   logic        ovf;

   int n_checks;
   int n_fail;

   spike_out_if spike_if [N] ();

   for (genvar g = 0; g < N; g++) begin : g_drv
      assign spike_if[g].valid  = v_m[g];
      assign spike_if[g].on_off = o_m[g];
   end

   spike_collector dut (
      .clk             (clk),
      .reset           (reset),
      .spike_in        (spike_if),
      .clear           (clr),
      .event_valid     (ev_valid),
      .event_ready     (rdy),
      .event_neuron    (ev_neuron),
      .event_on_off    (ev_on),
      .event_timestamp (ev_ts),
      .drop_count      (drop_cnt),
      .overflow        (ovf)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Expected FIFO contents as {neuron[1:0], on_off, timestamp[15:0]}.
   logic [18:0] exp_q [$];
   int          m_ts;
   bit          m_pend [N];
   logic        m_on   [N];
   logic [15:0] m_sts  [N];
   int          m_rr;
   int          m_drop;
   bit          m_ovf;

   task automatic model_reset();
      m_ts = 0; m_rr = 0; m_drop = 0; m_ovf = 0;
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 0; m_on[i] = 1'b0; m_sts[i] = '0;
      end
      exp_q.delete();
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      int g;
      if (clr) begin
         m_ts = 0; m_drop = 0; m_ovf = 0;
         for (int i = 0; i < N; i++) m_pend[i] = 0;
         exp_q.delete();
         return;
      end
      g = -1;
      if (exp_q.size() < DEPTH) begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (g < 0 && m_pend[idx]) g = idx;
         end
      end
      if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
      if (g >= 0) begin
         exp_q.push_back({2'(g), m_on[g], m_sts[g]});
         m_pend[g] = 0;
         m_rr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
         if (v_m[i]) begin
            if (m_pend[i]) begin
               m_ovf = 1;
               if (m_drop < 255) m_drop++;
            end else begin
               m_pend[i] = 1;
               m_on[i]   = o_m[i];
               m_sts[i]  = 16'(m_ts);
            end
         end
      end
      m_ts = (m_ts + 1) % 65536;
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      logic [18:0] h;
      check("valid", 32'(ev_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
         h = exp_q[0];
         check("neuron", 32'(ev_neuron), 32'(h[18:17]));
         check("on_off", 32'(ev_on), 32'(h[16]));
         check("timestamp", 32'(ev_ts), 32'(h[15:0]));
      end
      check("drop_count", 32'(drop_cnt), 32'(m_drop));
      check("overflow", 32'(ovf), 32'(m_ovf));
   endtask

   // ---------------- driver ----------------
   // One clock: model follows the current inputs, outputs sampled 1ns after the edge.
   task automatic cycle(input bit chk);
      model_step();
      @(posedge clk);
      #1;
      if (chk) compare_model();
   endtask

   task automatic drive(input logic [3:0] v, input logic [3:0] o);
      v_m = v;
      o_m = o;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [3:0]  v;
      logic [3:0]  o;
      logic        ev;
      logic [1:0]  en;
      logic        eo;
      logic [15:0] ets;
   } vec_t;

   vec_t tbl [15];
   int   got [32];
   int   cnt;

   initial begin
      // Rows start at the edge sampling timestamp 4, ready held high.
      tbl[0]  = '{4'h0, 4'h0, 1'b0, 2'd0, 1'b0, 16'd0};
      tbl[1]  = '{4'hF, 4'hA, 1'b0, 2'd0, 1'b0, 16'd0};   // burst at ts 5
      tbl[2]  = '{4'h0, 4'h0, 1'b1, 2'd0, 1'b0, 16'd5};
      tbl[3]  = '{4'h0, 4'h0, 1'b1, 2'd1, 1'b1, 16'd5};
      tbl[4]  = '{4'h0, 4'h0, 1'b1, 2'd2, 1'b0, 16'd5};
      tbl[5]  = '{4'h0, 4'h0, 1'b1, 2'd3, 1'b1, 16'd5};
      tbl[6]  = '{4'h4, 4'h4, 1'b0, 2'd0, 1'b0, 16'd0};   // single spike on 2 at ts 10
      tbl[7]  = '{4'h0, 4'h0, 1'b1, 2'd2, 1'b1, 16'd10};
      tbl[8]  = '{4'h0, 4'h0, 1'b0, 2'd0, 1'b0, 16'd0};
      tbl[9]  = '{4'hF, 4'hF, 1'b0, 2'd0, 1'b0, 16'd0};   // burst at ts 13, pointer at 3
      tbl[10] = '{4'h0, 4'h0, 1'b1, 2'd3, 1'b1, 16'd13};
      tbl[11] = '{4'h0, 4'h0, 1'b1, 2'd0, 1'b1, 16'd13};
      tbl[12] = '{4'h0, 4'h0, 1'b1, 2'd1, 1'b1, 16'd13};
      tbl[13] = '{4'h0, 4'h0, 1'b1, 2'd2, 1'b1, 16'd13};
      tbl[14] = '{4'h0, 4'h0, 1'b0, 2'd0, 1'b0, 16'd0};

      n_checks = 0;
      n_fail   = 0;
      reset = 1'b1; clr = 1'b0; rdy = 1'b1;
      drive(4'h0, 4'h0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_valid", 32'(ev_valid), 32'd0);
      check("reset_drop", 32'(drop_cnt), 32'd0);
      check("reset_ovf", 32'(ovf), 32'd0);
      check("reset_ts", 32'(ev_ts), 32'd0);
      reset = 1'b0;

      repeat (4) cycle(1);
      for (int r = 0; r < 15; r++) begin
         drive(tbl[r].v, tbl[r].o);
         cycle(1);
         check($sformatf("tbl%0d_valid", r), 32'(ev_valid), 32'(tbl[r].ev));
         if (tbl[r].ev) begin
            check($sformatf("tbl%0d_neuron", r), 32'(ev_neuron), 32'(tbl[r].en));
            check($sformatf("tbl%0d_on", r), 32'(ev_on), 32'(tbl[r].eo));
            check($sformatf("tbl%0d_ts", r), 32'(ev_ts), 32'(tbl[r].ets));
         end
      end

      // Collision: 0 and 1 fire twice in a row; slot 0 wins the grant and reloads, 1 drops.
      drive(4'h3, 4'h3); cycle(1);
      drive(4'h3, 4'h3); cycle(1);
      check("coll_drop", 32'(drop_cnt), 32'd1);
      check("coll_ovf", 32'(ovf), 32'd1);
      drive(4'h0, 4'h0);
      repeat (5) cycle(1);

      // Clear wipes counters and flags.
      clr = 1'b1; cycle(1); clr = 1'b0;
      check("clr_drop", 32'(drop_cnt), 32'd0);
      check("clr_ovf", 32'(ovf), 32'd0);
      check("clr_valid", 32'(ev_valid), 32'd0);

      // FIFO full: 20 spikes on input 0 every other cycle with the consumer stalled.
      rdy = 1'b0;
      for (int s = 0; s < 20; s++) begin
         drive(4'h1, 4'h1); cycle(1);
         drive(4'h0, 4'h0); cycle(1);
      end
      check("full_drop", 32'(drop_cnt), 32'd3);
      check("full_ovf", 32'(ovf), 32'd1);
      check("full_valid", 32'(ev_valid), 32'd1);
      check("full_head_ts", 32'(ev_ts), 32'd0);
      rdy = 1'b1;
      cnt = 0;
      for (int k = 0; k < 32; k++) got[k] = -1;
      for (int c = 0; c < 40; c++) begin
         if (ev_valid && cnt < 32) begin
            got[cnt] = int'(ev_ts);
            cnt++;
         end
         cycle(1);
      end
      check("drain_count", 32'(cnt), 32'd17);
      for (int k = 0; k < 17; k++) check($sformatf("drain_ts%0d", k), 32'(got[k]), 32'(2 * k));

      // Saturation: every input fires continuously against a stalled FIFO.
      rdy = 1'b0;
      for (int c = 0; c < 100; c++) begin
         drive(4'hF, 4'($urandom_range(0, 15)));
         cycle(1);
      end
      check("sat_drop", 32'(drop_cnt), 32'd255);
      check("sat_ovf", 32'(ovf), 32'd1);
      drive(4'h0, 4'h0);
      clr = 1'b1; cycle(1); clr = 1'b0;
      check("sat_clr_drop", 32'(drop_cnt), 32'd0);
      check("sat_clr_ovf", 32'(ovf), 32'd0);
      check("sat_clr_valid", 32'(ev_valid), 32'd0);
      rdy = 1'b1;
      drive(4'h2, 4'h2); cycle(1);
      drive(4'h0, 4'h0); cycle(1);
      check("restart_valid", 32'(ev_valid), 32'd1);
      check("restart_neuron", 32'(ev_neuron), 32'd1);
      check("restart_ts", 32'(ev_ts), 32'd0);
      cycle(1);

      // Randomized traffic with occasional clears and consumer stalls.
      for (int c = 0; c < 1500; c++) begin
         logic [3:0] v;
         for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 9) < 3);
         drive(v, 4'($urandom_range(0, 15)));
         rdy = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 99) == 0);
         cycle(1);
      end
      clr = 1'b0; rdy = 1'b1;

      // Async reset between edges while events are queued and drops counted.
      drive(4'hF, 4'hF); cycle(1);
      drive(4'hF, 4'hF); cycle(1);
      drive(4'h0, 4'h0); cycle(1);
      #3;
      reset = 1'b1;
      #1;
      check("areset_valid", 32'(ev_valid), 32'd0);
      check("areset_neuron", 32'(ev_neuron), 32'd0);
      check("areset_on", 32'(ev_on), 32'd0);
      check("areset_ts", 32'(ev_ts), 32'd0);
      check("areset_drop", 32'(drop_cnt), 32'd0);
      check("areset_ovf", 32'(ovf), 32'd0);
      model_reset();
      #2;
      reset = 1'b0;

      // Timestamp wrap: spikes on input 3 sampled at 65534, 65535, 0, 1.
      while (m_ts != 65534) cycle(0);
      cnt = 0;
      for (int k = 0; k < 32; k++) got[k] = -1;
      for (int c = 0; c < 9; c++) begin
         if (c < 4) drive(4'h8, 4'h8);
         else drive(4'h0, 4'h0);
         if (ev_valid && cnt < 32) begin
            got[cnt] = int'(ev_ts);
            cnt++;
         end
         cycle(1);
      end
      check("wrap_count", 32'(cnt), 32'd4);
      check("wrap_ts0", 32'(got[0]), 32'd65534);
      check("wrap_ts1", 32'(got[1]), 32'd65535);
      check("wrap_ts2", 32'(got[2]), 32'd0);
      check("wrap_ts3", 32'(got[3]), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spike_collector.md
# spike_collector

Receiving end of the neuron spike output interface. Samples `spike_out_if` ports of up to NUM_NEURONS neurons every clock, tags each event with neuron index, on/off flag and a free-running timestamp, arbitrates round-robin into an event FIFO and presents events on a valid/ready stream toward the readout/host logic. The spike interface has no backpressure, so the block absorbs collisions in per-input pending slots and counts dropped events.

## Interface

Parameters:
- NUM_NEURONS, 4, number of `spike_out_if` inputs (≥2)
- TIMESTAMP_WIDTH, 16, width of timestamp counter and event field
- FIFO_DEPTH, 16, event FIFO entries (power of two)
- DROP_WIDTH, 8, width of saturating drop counter

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- spike_in[NUM_NEURONS]  spike_out_if.slave  —  per-neuron spike port (`valid`, `on_off`); block only reads
- clear  input  1  synchronous: zero timestamp counter, drop counter, overflow flag; flush pending slots and FIFO
- event_valid  output  1  FIFO head valid
- event_ready  input  1  consumer accepts head when event_valid && event_ready
- event_neuron  output  $clog2(NUM_NEURONS)  source index of head event
- event_on_off  output  1  1 = spike onset, 0 = refractory end
- event_timestamp  output  TIMESTAMP_WIDTH  counter value in cycle the spike was sampled
- drop_count  output  DROP_WIDTH  saturating count of lost events
- overflow  output  1  sticky, set on first drop

## Operation

- Timestamp counter: increments every cycle, wraps 2^TIMESTAMP_WIDTH−1 → 0; no wrap flag.
- Capture: at an edge where `spike_in[i].valid`=1, slot i loads {on_off, timestamp} and sets pending[i]. `on_off` is ignored when valid=0.
- Arbitration: each cycle, if FIFO not full, round-robin picks one pending slot starting at index after last granted (initial pointer 0 → first priority index 0); winner written to FIFO and its pending cleared on same edge.
- Collision: valid on input i while pending[i]=1 and slot i not granted this cycle → new event dropped (older kept), drop_count += 1 saturating at 2^DROP_WIDTH−1, overflow set. If slot i is granted in the same cycle, new event loads (no drop).
- Multiple drops in one cycle add their total (saturating).
- FIFO full: no grant; pending slots hold; collisions drop per rule above.
- Output: first-word-fall-through; head fields stable while event_valid && !event_ready. Push and pop same cycle with FIFO full is allowed only as pop-then-grant next cycle (no grant when full at edge).
- clear has priority over capture/grant/pop in that cycle; valids in the clear cycle are discarded without counting.
- Reset (async): counter 0, pending all 0, RR pointer 0, FIFO empty, event_valid 0, event_neuron/on_off/timestamp 0, drop_count 0, overflow 0. Reset mid-stream discards all queued events.

## Timing

- Spike valid sampled at edge N → pending at N → written to FIFO at edge N+1 (if granted) → event_valid high from N+1. Minimum latency 2 edges.
- Throughput: one event per cycle in and out.
- Timestamp = counter value before edge N (equals N mod 2^TIMESTAMP_WIDTH cycles after reset release).
- drop_count/overflow update on the edge of the collision.
- Worst case with NUM_NEURONS simultaneous spikes and empty FIFO: last event enters FIFO NUM_NEURONS edges later, timestamps all equal.

## Structure

- Package `spike_pkg`: `spike_event_t` struct {neuron, on_off, timestamp}, width localparams derived from parameters.
- Sub-module `spike_event_fifo`: synchronous FWFT FIFO of `spike_event_t`, full/empty, async reset, flush input driven by clear.
- Top holds timestamp counter, pending slots, round-robin arbiter, drop counter.

## Test plan

- Single spike: valid/on_off=1 on input 2 at timestamp 10, event_ready=1 → event {2,1,10} with event_valid for exactly one cycle, 2 edges later.
- All 4 inputs valid at timestamp 5 → four events in order 0,1,2,3, all timestamp 5, on consecutive cycles; next burst starts at 0's successor per RR pointer (order 0..3 after grant 3).
- Collision: input 1 valid two consecutive cycles while inputs 0 also firing and FIFO not full → second event of 1 dropped only if slot 1 not granted; check drop_count=1, overflow=1.
- FIFO full: event_ready=0, 20 spikes on input 0 spaced 2 cycles → 16 queued, 1 pending, 3 dropped; drop_count=3; release ready → 17 events drained in order.
- Drop saturation: force 300 drops with DROP_WIDTH=8 → drop_count=255; clear → drop_count=0, overflow=0, event_valid=0, timestamp restarts 0.
- Async reset asserted mid-burst between edges → all outputs 0 immediately; timestamp wrap 65535→0 verified on events straddling wrap.
